// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: command sequencer driving an external combinational ALU.
// Optional status flags enabled by defining ALU_SEQ_FLAGS_EN.
module alu_cmd_seq #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_op_i,
    input  logic              cmd_ld_i,
    input  logic [1:0]        cmd_rd_i,
    input  logic [1:0]        cmd_ra_i,
    input  logic [1:0]        cmd_rb_i,
    input  logic              cmd_imm_en_i,
    input  logic [DATA_W-1:0] cmd_imm_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [2:0]        alu_op_o,
    input  logic [DATA_W-1:0] alu_res_i,
    input  logic              alu_carry_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_carry_o,
    output logic              flag_z_o,
    output logic              flag_c_o
);

    localparam logic [2:0] OP_ADD = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        rd_q;
    logic [DATA_W-1:0] regs [NREG];

    // Carry is only meaningful for ADD; all other ops report zero.
    logic add_carry;
    assign add_carry = (alu_op_o == OP_ADD) & alu_carry_i;

    // Sequencer FSM, register file, ALU issue ports and response registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_carry_o <= 1'b0;
            alu_a_o     <= '0;
            alu_b_o     <= '0;
            alu_op_o    <= '0;
            rd_q        <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        cmd_ready_o <= 1'b0;
                        if (cmd_ld_i) begin
                            regs[cmd_rd_i] <= cmd_imm_i;
                            rsp_data_o     <= cmd_imm_i;
                            rsp_carry_o    <= 1'b0;
                            rsp_valid_o    <= 1'b1;
                            state          <= RESP;
                        end else begin
                            // Operands read here, before any write-back.
                            alu_a_o  <= regs[cmd_ra_i];
                            alu_b_o  <= cmd_imm_en_i ? cmd_imm_i
                                                     : regs[cmd_rb_i];
                            alu_op_o <= cmd_op_i;
                            rd_q     <= cmd_rd_i;
                            state    <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    regs[rd_q]  <= alu_res_i;
                    rsp_data_o  <= alu_res_i;
                    rsp_carry_o <= add_carry;
                    rsp_valid_o <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_o <= 1'b0;
                    cmd_ready_o <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic flag_z_q;
    logic flag_c_q;

    // Flags follow ALU results only; loads leave them untouched.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else if (state == EXEC) begin
            flag_z_q <= (alu_res_i == '0);
            flag_c_q <= add_carry;
        end
    end

    assign flag_z_o = flag_z_q;
    assign flag_c_o = flag_c_q;
`else
    assign flag_z_o = 1'b0;
    assign flag_c_o = 1'b0;
`endif

endmodule
